hrm_outbox: RTL



---
 rtl/hrm_pkg.sv | 11 +
 rtl/hrm_outbox_if.sv | 31 +++
 rtl/hrm_outbox_mem.sv | 24 ++
 rtl/hrm_outbox.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hrm_pkg.sv
// Shared types and constants for the hrmcpu OUTBOX queue.
package hrm_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    OB_EMPTY = 1'b0,
    OB_HEAD  = 1'b1
  } ob_state_t;

endpackage

// File: rtl/hrm_outbox_if.sv
// Push/pop bus of the OUTBOX queue. The slave modport is the queue, and master is the CPU/consumer side.
// The error signals exist only when OUTBOX_ERR_EN is defined.
interface hrm_outbox_if #(
  parameter int AW = 3
);
  import hrm_pkg::*;

  logic              i_wr;
  logic [DATA_W-1:0] i_data;
  logic              o_full;
  logic              i_rd;
  logic [DATA_W-1:0] o_data;
  logic              o_empty;
  logic [AW:0]       o_level;
`ifdef OUTBOX_ERR_EN
  logic              i_err_clr;
  logic              o_err_ovf;
  logic              o_err_udf;

  modport slave  (input  i_wr, i_data, i_rd, i_err_clr,
                  output o_full, o_data, o_empty, o_level, o_err_ovf, o_err_udf);
  modport master (output i_wr, i_data, i_rd, i_err_clr,
                  input  o_full, o_data, o_empty, o_level, o_err_ovf, o_err_udf);
`else
  modport slave  (input  i_wr, i_data, i_rd,
                  output o_full, o_data, o_empty, o_level);
  modport master (output i_wr, i_data, i_rd,
                  input  o_full, o_data, o_empty, o_level);
`endif

endinterface

// File: rtl/hrm_outbox_mem.sv
// OUTBOX backing store. Writes are synchronous and reads are asynchronous.
// The contents are never reset. No backpressure is applied here; the caller gates we.
module hrm_outbox_mem
  import hrm_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/hrm_outbox.sv
// FWFT OUTBOX queue. A push becomes visible one cycle later, and a pop advances the head one cycle later.
// A push while full with no pop is dropped, and a pop while empty is dropped. OUTBOX_ERR_EN adds sticky error flags.
module hrm_outbox
  import hrm_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             i_rst,
  hrm_outbox_if.slave      bus
);

  localparam int CAP = 2**AW;

  ob_state_t         state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;

  logic              full, pv, wv, arr_empty, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  hrm_outbox_mem #(.AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.i_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign full      = (level_q == (AW+1)'(CAP));
  assign pv        = bus.i_rd && (state_q == OB_HEAD);
  assign wv        = bus.i_wr && (!full || pv);
  // The head register holds one entry, so the array is empty while the level is below 2.
  assign arr_empty = (level_q < (AW+1)'(2));

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_we   = 1'b0;

    if (wv && !pv)      level_d = level_q + (AW+1)'(1);
    else if (pv && !wv) level_d = level_q - (AW+1)'(1);

    case (state_q)
      OB_EMPTY: begin
        if (wv) begin
          head_d  = bus.i_data;
          state_d = OB_HEAD;
        end
      end
      OB_HEAD: begin
        if (pv && !arr_empty) begin
          head_d   = mem_rdata;
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (wv) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end else if (pv) begin
          if (wv) head_d  = bus.i_data;
          else    state_d = OB_EMPTY;
        end else if (wv) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      default: state_d = OB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= OB_EMPTY;
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign bus.o_data  = head_q;
  assign bus.o_empty = (state_q == OB_EMPTY);
  assign bus.o_full  = full;
  assign bus.o_level = level_q;

`ifdef OUTBOX_ERR_EN
  logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  // A clear takes priority over a set in the same cycle.
  always_comb begin
    err_ovf_d = err_ovf_q | (bus.i_wr && !wv);
    err_udf_d = err_udf_q | (bus.i_rd && (state_q == OB_EMPTY));
    if (bus.i_err_clr) begin
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign bus.o_err_ovf = err_ovf_q;
  assign bus.o_err_udf = err_udf_q;
`endif

endmodule
